// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
//
// Receive side of a VGA-style timing interface. The hs/vs/blank signals from
// a timing generator are sampled on every clk where pix_ce=1. The block
// recovers the pixel coordinates, line and frame strobes, and the measured
// line and frame lengths. It also acts as a timing checker: it locks once a
// full frame matches the expected geometry and pulses timing_err whenever a
// locked stream drifts.
//
// Ports
//   clk          system clock; all state lives in this domain
//   reset        asynchronous, active-high reset
//   pix_ce       pixel sample enable; nothing advances while it is 0
//   hs, vs       horizontal / vertical sync, active low
//   blank        display enable, 1 = active pixel
//   de           registered copy of blank for the sampled pixel
//   draw_x       column of the sampled active pixel, 0 outside active video
//   draw_y       row of the current active line
//   line_start   one-clk pulse on a detected hs falling edge
//   frame_start  one-clk pulse on a detected vs falling edge
//   h_total_meas samples in the last completed line
//   v_total_meas lines in the last completed frame
//   locked       1 while the incoming timing matches all parameters
//   timing_err   one-clk pulse on any mismatch while locked
//
// Every registered output reflects the sample taken on a pix_ce clk and
// becomes visible on the following clk.
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic       hs,
  input  logic       vs,
  input  logic       blank,
  output logic       de,
  output logic [9:0] draw_x,
  output logic [9:0] draw_y,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] h_total_meas,
  output logic [9:0] v_total_meas,
  output logic       locked,
  output logic       timing_err
);

  localparam logic [9:0] CNT_MAX    = 10'd1023;
  localparam logic [9:0] H_TOTAL_C  = 10'(H_TOTAL);
  localparam logic [9:0] V_TOTAL_C  = 10'(V_TOTAL);
  localparam logic [9:0] H_ACTIVE_C = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACTIVE_C = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state;

  // Previous sync levels. They reset low so that a sync that is already low
  // when reset releases is never mistaken for a falling edge.
  logic       hs_q;
  logic       vs_q;

  logic [9:0] h_cnt;       // samples since the last hs falling edge
  logic [9:0] x_cnt;       // active samples since the last hs falling edge
  logic [9:0] v_cnt;       // hs falling edges since the last vs falling edge
  logic [9:0] h_act_last;  // active width of the last completed active line
  logic       line_act;    // current line has carried at least one active pixel

  function automatic logic [9:0] sat_inc(input logic [9:0] val);
    return (val == CNT_MAX) ? val : val + 10'd1;
  endfunction

  // -------------------------------------------------------------------------
  // Per-sample decode. The "eff" values are what the measurements will hold
  // once the current sample has been absorbed, so that an hs edge landing on
  // the same sample as a vs edge is credited to the frame that is ending.
  // -------------------------------------------------------------------------
  logic       hs_fall;
  logic       vs_fall;
  logic       act_line_end;
  logic [9:0] h_len;
  logic [9:0] v_len;
  logic [9:0] y_act_seen;
  logic [9:0] h_meas_eff;
  logic [9:0] h_act_eff;
  logic       line_bad;
  logic       frame_bad;
  logic       sync_lost;
  logic       frame_ok;

  always_comb begin
    hs_fall      = hs_q & ~hs;
    vs_fall      = vs_q & ~vs;
    act_line_end = hs_fall & line_act;

    // 10-bit length of the line that this hs edge closes; a saturated
    // counter wraps to 0 here, which can never match a real line length.
    h_len        = h_cnt + 10'd1;

    v_len        = hs_fall ? sat_inc(v_cnt) : v_cnt;
    y_act_seen   = act_line_end ? sat_inc(draw_y) : draw_y;
    h_meas_eff   = hs_fall ? h_len : h_total_meas;
    h_act_eff    = act_line_end ? x_cnt : h_act_last;

    line_bad     = hs_fall && ((h_len != H_TOTAL_C) ||
                               (line_act && (x_cnt != H_ACTIVE_C)));
    frame_bad    = vs_fall && ((v_len != V_TOTAL_C) ||
                               (y_act_seen != V_ACTIVE_C));

    // Fires once, on the increment that lands the line counter on its
    // ceiling; an hs edge on that sample restarts the count instead.
    sync_lost    = !hs_fall && (h_cnt == CNT_MAX - 10'd1);

    frame_ok     = (v_len      == V_TOTAL_C)  &&
                   (h_meas_eff == H_TOTAL_C)  &&
                   (y_act_seen == V_ACTIVE_C) &&
                   (h_act_eff  == H_ACTIVE_C);
  end

  // -------------------------------------------------------------------------
  // Sync edge history and the two strobes. The strobes are cleared on every
  // clk so they never stretch across gaps in pix_ce.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        hs_q        <= hs;
        vs_q        <= vs;
        line_start  <= hs_fall;
        frame_start <= vs_fall;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Horizontal measurement: line length and active width.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt        <= 10'd0;
      h_total_meas <= 10'd0;
      h_act_last   <= 10'd0;
    end else if (pix_ce) begin
      if (hs_fall) begin
        h_cnt        <= 10'd0;
        h_total_meas <= h_len;
      end else begin
        h_cnt <= sat_inc(h_cnt);
      end
      if (act_line_end) begin
        h_act_last <= x_cnt;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pixel position. An active sample that coincides with an hs edge is taken
  // as column 0 of the new line.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de       <= 1'b0;
      draw_x   <= 10'd0;
      x_cnt    <= 10'd0;
      line_act <= 1'b0;
    end else if (pix_ce) begin
      de <= blank;
      if (blank) begin
        draw_x   <= hs_fall ? 10'd0 : x_cnt;
        x_cnt    <= hs_fall ? 10'd1 : sat_inc(x_cnt);
        line_act <= 1'b1;
      end else begin
        draw_x <= 10'd0;
        if (hs_fall) begin
          x_cnt    <= 10'd0;
          line_act <= 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Vertical measurement. draw_y doubles as the count of active lines seen
  // in the current frame; the vs edge restarts both counts after the ending
  // frame has been measured.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_cnt        <= 10'd0;
      v_total_meas <= 10'd0;
      draw_y       <= 10'd0;
    end else if (pix_ce) begin
      if (vs_fall) begin
        v_total_meas <= v_len;
        v_cnt        <= 10'd0;
        draw_y       <= 10'd0;
      end else begin
        if (hs_fall) begin
          v_cnt <= sat_inc(v_cnt);
        end
        if (act_line_end) begin
          draw_y <= sat_inc(draw_y);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Lock tracking. The first vs edge only aligns to the stream; the frame
  // that follows must match every parameter before locked is raised. Once
  // locked, any deviation raises a single timing_err pulse and restarts the
  // search, while all measurements carry on regardless.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SEARCH;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      timing_err <= 1'b0;
      if (pix_ce) begin
        case (state)
          SEARCH: begin
            locked <= 1'b0;
            if (vs_fall) begin
              state <= CHECK;
            end
          end
          CHECK: begin
            if (vs_fall && frame_ok) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (line_bad || frame_bad || sync_lost) begin
              timing_err <= 1'b1;
              locked     <= 1'b0;
              state      <= SEARCH;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Directed bench for vga_sync_decoder, using a reduced raster so that many
// frames fit in a short run. Expected output values are queued at the moment
// a sample is driven and compared right after the clk that consumes it.
// pix_ce is high on every second clk.
// ---------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int HT       = 48;
  localparam int HA       = 32;
  localparam int VT       = 24;
  localparam int VA       = 16;
  localparam int HS_START = HA + 4;
  localparam int HS_LEN   = 8;
  localparam int VS_START = VA + 2;
  localparam int VS_LEN   = 2;

  localparam int S_DE = 0;
  localparam int S_X  = 1;
  localparam int S_Y  = 2;
  localparam int S_LS = 3;
  localparam int S_FS = 4;
  localparam int S_HM = 5;
  localparam int S_VM = 6;
  localparam int S_LK = 7;
  localparam int S_TE = 8;

  logic       clk;
  logic       reset;
  logic       pix_ce;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       de;
  logic [9:0] draw_x;
  logic [9:0] draw_y;
  logic       line_start;
  logic       frame_start;
  logic [9:0] h_total_meas;
  logic [9:0] v_total_meas;
  logic       locked;
  logic       timing_err;

  int checks = 0;
  int errors = 0;
  int te_pulses = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  vga_sync_decoder #(
    .H_TOTAL (HT),
    .V_TOTAL (VT),
    .H_ACTIVE(HA),
    .V_ACTIVE(VA)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .hs          (hs),
    .vs          (vs),
    .blank       (blank),
    .de          (de),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .h_total_meas(h_total_meas),
    .v_total_meas(v_total_meas),
    .locked      (locked),
    .timing_err  (timing_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // timing_err is a registered output; counting it mid-cycle sees each
  // high clk exactly once.
  always @(negedge clk) begin
    if (timing_err === 1'b1) te_pulses++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: observed no finish, expected finish before 3 ms");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] observe(input int sel);
    logic [31:0] r;
    r = '0;
    case (sel)
      S_DE:    r = {31'b0, de};
      S_X:     r = {22'b0, draw_x};
      S_Y:     r = {22'b0, draw_y};
      S_LS:    r = {31'b0, line_start};
      S_FS:    r = {31'b0, frame_start};
      S_HM:    r = {22'b0, h_total_meas};
      S_VM:    r = {22'b0, v_total_meas};
      S_LK:    r = {31'b0, locked};
      S_TE:    r = {31'b0, timing_err};
      default: r = 'x;
    endcase
    return r;
  endfunction

  function automatic void expect_out(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic expect_all_zero(input string tag);
    expect_out({tag, "_de"}, S_DE, 0);
    expect_out({tag, "_draw_x"}, S_X, 0);
    expect_out({tag, "_draw_y"}, S_Y, 0);
    expect_out({tag, "_line_start"}, S_LS, 0);
    expect_out({tag, "_frame_start"}, S_FS, 0);
    expect_out({tag, "_h_total"}, S_HM, 0);
    expect_out({tag, "_v_total"}, S_VM, 0);
    expect_out({tag, "_locked"}, S_LK, 0);
    expect_out({tag, "_timing_err"}, S_TE, 0);
  endtask

  // One pixel sample on a pix_ce clk followed by one idle clk.
  task automatic step(input logic h, input logic v, input logic b, input bit gap_chk);
    @(negedge clk);
    pix_ce = 1'b1;
    hs     = h;
    vs     = v;
    blank  = b;
    @(posedge clk);
    #1;
    drain();
    @(negedge clk);
    pix_ce = 1'b0;
    @(posedge clk);
    #1;
    if (gap_chk) begin
      expect_out("gap_line_start", S_LS, 0);
      drain();
    end
  endtask

  task automatic run_frame(input int nlines, input int stretch_line, input bit check_px,
                           input bit exp_lock_vs, input int exp_vtot);
    int   hlen;
    logic hs_v;
    logic vs_v;
    logic b;
    bit   gap;
    for (int v = 0; v < nlines; v++) begin
      hlen = (v == stretch_line) ? HT + 1 : HT;
      for (int h = 0; h < hlen; h++) begin
        hs_v = !((h >= HS_START) && (h < HS_START + HS_LEN));
        vs_v = !((v >= VS_START) && (v < VS_START + VS_LEN));
        b    = (v < VA) && (h < HA);
        gap  = 1'b0;
        if (check_px) begin
          if (v == 0 && h == 0) begin
            expect_out("first_px_de", S_DE, 1);
            expect_out("first_px_x", S_X, 0);
            expect_out("first_px_y", S_Y, 0);
          end
          if (v == 0 && h == HA - 1) begin
            expect_out("last_px_de", S_DE, 1);
            expect_out("last_px_x", S_X, HA - 1);
          end
          if (v == 1 && h == HA) begin
            expect_out("blank_de", S_DE, 0);
            expect_out("blank_x", S_X, 0);
            expect_out("line1_y", S_Y, 1);
          end
          if (v == 1 && h == HS_START) begin
            expect_out("line_start", S_LS, 1);
            gap = 1'b1;
          end
          if (v == 1 && h == HS_START + 1) begin
            expect_out("line_start_end", S_LS, 0);
          end
        end
        if (v == VS_START && h == 0) begin
          expect_out("frame_start", S_FS, 1);
          expect_out("vs_locked", S_LK, exp_lock_vs);
          expect_out("vs_h_total", S_HM, HT);
          if (exp_vtot >= 0) expect_out("vs_v_total", S_VM, exp_vtot);
        end
        if (stretch_line >= 0 && v == stretch_line + 1 && h == HS_START) begin
          expect_out("stretch_err", S_TE, 1);
          expect_out("stretch_locked", S_LK, 0);
        end
        if (stretch_line >= 0 && v == stretch_line + 1 && h == HS_START + 1) begin
          expect_out("stretch_err_end", S_TE, 0);
        end
        step(hs_v, vs_v, b, gap);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    pix_ce = 1'b0;
    hs     = 1'b1;
    vs     = 1'b1;
    blank  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    expect_all_zero("reset");
    drain();
    @(negedge clk);
    reset = 1'b0;

    // Clean stream: align on first vs edge, lock on the second.
    run_frame(VT, -1, 1'b0, 1'b0, VA + 2);
    run_frame(VT, -1, 1'b0, 1'b1, VT);
    run_frame(VT, -1, 1'b1, 1'b1, VT);

    // One line one pixel too long, then relock two vs edges later.
    run_frame(VT, 2, 1'b0, 1'b0, VT);
    run_frame(VT, -1, 1'b0, 1'b1, VT);

    // hs stuck high: the line counter hits its ceiling while locked.
    for (int i = 0; i < 1100; i++) begin
      if (i == 1011) begin
        expect_out("sat_err", S_TE, 1);
        expect_out("sat_locked", S_LK, 0);
        expect_out("sat_h_total", S_HM, HT);
      end
      if (i == 1012) expect_out("sat_err_end", S_TE, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Short frame while checking: no lock until a full-length frame follows.
    run_frame(VT - 1, -1, 1'b0, 1'b0, VT);
    run_frame(VT, -1, 1'b0, 1'b0, VT - 1);
    run_frame(VT, -1, 1'b0, 1'b1, VT);

    // Reset mid-line while locked, with hs low across the release.
    for (int h = 0; h < HS_START + 2; h++) begin
      if (h == HS_START) begin
        expect_out("pre_reset_line_start", S_LS, 1);
        expect_out("pre_reset_locked", S_LK, 1);
      end
      step((h >= HS_START) ? 1'b0 : 1'b1, 1'b1, (h < HA) ? 1'b1 : 1'b0, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    expect_all_zero("mid_reset");
    drain();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out("release_no_line_start", S_LS, 0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("first_edge_after_reset", S_LS, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(VT, -1, 1'b0, 1'b0, -1);
    run_frame(VT, -1, 1'b0, 1'b1, VT);

    check("timing_err_pulse_total", te_pulses, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
